result_byte_serializer: RTL

- Downstream readout stage for the matrix-multiply datapath.
- After the controller signals `finish`, it reads the 18-bit results from the result SRAM one word at a time and emits each word as 3 bytes, MSB first.
- Output is an 8-bit valid/ready stream toward the chip output interface.
- It owns the SRAM read port while busy; it pulses `done` once the last byte has been accepted.

---
 rtl/result_byte_serializer.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/result_byte_serializer.sv
// result_byte_serializer
//
// Readout stage for the matrix-multiply datapath. On a start pulse it reads
// result words 0..NUM_RESULTS-1 from the result SRAM, one at a time, and
// emits each word as three bytes, MSB first, on an 8-bit valid/ready stream.
// It owns the SRAM read port while busy and pulses done once the last byte
// has been accepted.
//
// Optional feature (compile-time macro RESULT_SER_CHECKSUM_EN):
//   When defined, an 8-bit XOR of every accepted data byte is appended as
//   one extra byte after the last word.
//
// Ports:
//   clk        system clock
//   reset_n    asynchronous active-low reset
//   start      one-cycle pulse, begins a readout pass (only honoured in IDLE)
//   ram_re     SRAM read request, high for one cycle per word
//   ram_addr   SRAM read address
//   ram_rdata  SRAM read data, valid the cycle after ram_re
//   out_data   output byte
//   out_valid  out_data valid
//   out_ready  downstream accepts a byte when out_valid & out_ready
//   busy       high while a pass is in progress
//   done       one-cycle pulse after the final byte is accepted
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | waiting for start; all outputs quiet
// RD_REQ  | ram_re high for one cycle at the current address
// RD_WAIT | SRAM data returns; captured into the byte shift register
// SEND    | presenting shift_q[23:16]; shifts on each accepted byte
// CSUM    | (checksum build only) presenting the XOR checksum byte
// DONE    | done pulse, busy low, back to IDLE

module result_byte_serializer #(
  parameter int NUM_RESULTS = 16,
  parameter int RES_W       = 18,
  parameter int ADDR_W      = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  output logic              ram_re,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [RES_W-1:0]  ram_rdata,
  output logic [7:0]        out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done
);

`ifdef RESULT_SER_CHECKSUM_EN
  typedef enum logic [2:0] {
    S_IDLE, S_RD_REQ, S_RD_WAIT, S_SEND, S_CSUM, S_DONE
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_RD_REQ, S_RD_WAIT, S_SEND, S_DONE
  } state_t;
`endif

  // Index of the final word, one bit wider so NUM_RESULTS = 2**ADDR_W fits.
  localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W+1)'(NUM_RESULTS - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_cnt_q;
  logic [1:0]        byte_idx_q;
  logic [23:0]       shift_q;
  logic [23:0]       rdata_ext;

  logic cnt_clr, cnt_inc, sr_load, sr_shift, accept;

`ifdef RESULT_SER_CHECKSUM_EN
  logic [7:0] csum_q;
`endif

  always_comb begin
    rdata_ext = '0;
    rdata_ext[RES_W-1:0] = ram_rdata;
  end

  assign ram_addr = addr_cnt_q;
  assign accept   = out_valid & out_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ram_re    = 1'b0;
    out_valid = 1'b0;
    out_data  = 8'h00;
    busy      = 1'b0;
    done      = 1'b0;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    sr_load   = 1'b0;
    sr_shift  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          cnt_clr = 1'b1;
          state_d = S_RD_REQ;
        end
      end
      S_RD_REQ: begin
        busy    = 1'b1;
        ram_re  = 1'b1;
        state_d = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        busy    = 1'b1;
        sr_load = 1'b1;
        state_d = S_SEND;
      end
      S_SEND: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        out_data  = shift_q[23:16];
        if (out_ready) begin
          if (byte_idx_q != 2'd2) begin
            sr_shift = 1'b1;
          end else if ({1'b0, addr_cnt_q} < LAST_IDX) begin
            cnt_inc = 1'b1;
            state_d = S_RD_REQ;
          end else begin
`ifdef RESULT_SER_CHECKSUM_EN
            state_d = S_CSUM;
`else
            state_d = S_DONE;
`endif
          end
        end
      end
`ifdef RESULT_SER_CHECKSUM_EN
      S_CSUM: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        out_data  = csum_q;
        if (out_ready) begin
          state_d = S_DONE;
        end
      end
`endif
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Datapath: address counter, byte index and byte shift register.
  // The outgoing byte is always shift_q[23:16]; accepting a non-final byte
  // shifts the next one up, so a stall simply leaves everything in place.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_cnt_q <= '0;
      byte_idx_q <= 2'd0;
      shift_q    <= 24'h0;
    end else begin
      if (cnt_clr) begin
        addr_cnt_q <= '0;
      end else if (cnt_inc) begin
        addr_cnt_q <= addr_cnt_q + ADDR_W'(1);
      end
      if (sr_load) begin
        shift_q    <= rdata_ext;
        byte_idx_q <= 2'd0;
      end else if (sr_shift) begin
        shift_q    <= {shift_q[15:0], 8'h00};
        byte_idx_q <= byte_idx_q + 2'd1;
      end
    end
  end

`ifdef RESULT_SER_CHECKSUM_EN
  // Only data bytes feed the checksum; the checksum byte itself is excluded.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      csum_q <= 8'h00;
    end else if (cnt_clr) begin
      csum_q <= 8'h00;
    end else if (accept && state_q == S_SEND) begin
      csum_q <= csum_q ^ shift_q[23:16];
    end
  end
`endif

endmodule
